// File: rtl/requant_bias_scale_act_if.sv
// Stream bundle for the requantiser: accumulator beats in (s_*), activations out (m_*).
// master = upstream/downstream environment view, slave = requantiser view.
interface requant_bias_scale_act_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int CH_W       = 4
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  m_valid;
    logic                  m_ready;
    logic [OUT_WIDTH-1:0]  m_data;
    logic [CH_W-1:0]       m_ch;
    logic                  m_last;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_ch, m_last
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_ch, m_last
    );
endinterface

// File: rtl/requant_bias_scale_act.sv
// Per-channel requantiser: (acc + bias[ch]) * scale[ch], round half up, activation, saturate.
// Two-stage valid/ready pipeline, one beat per cycle, runtime-writable bias/scale tables.
module requant_bias_scale_act #(
    parameter int  DATA_WIDTH  = 32,
    parameter int  BIAS_WIDTH  = 32,
    parameter int  SCALE_WIDTH = 16,
    parameter int  FRAC_BITS   = 8,
    parameter int  OUT_WIDTH   = 8,
    parameter int  NUM_CH      = 16,
    localparam int CH_W        = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [CH_W-1:0]        cfg_addr,
    input  logic [BIAS_WIDTH-1:0]  cfg_bias,
    input  logic [SCALE_WIDTH-1:0] cfg_scale,
    input  logic [1:0]             act_mode,
    input  logic [OUT_WIDTH-1:0]   cfg_clip,
    output logic                   err,
    requant_bias_scale_act_if.slave bus
);
    typedef enum logic [1:0] {
        ACT_LINEAR = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_CLIP   = 2'd2,
        ACT_RELU_B = 2'd3
    } act_e;

    localparam int SUM_W  = ((DATA_WIDTH > BIAS_WIDTH) ? DATA_WIDTH : BIAS_WIDTH) + 1;
    localparam int PROD_W = SUM_W + SCALE_WIDTH;
    localparam logic [CH_W-1:0]               LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic signed [SCALE_WIDTH-1:0] SCALE_ONE  = SCALE_WIDTH'(1) << FRAC_BITS;
    localparam logic signed [PROD_W-1:0]      ROUND_HALF = PROD_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [PROD_W-1:0]      OUT_MAX    = PROD_W'((longint'(1) << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [PROD_W-1:0]      OUT_MIN    = -OUT_MAX - PROD_W'(1);

    logic signed [BIAS_WIDTH-1:0]  bias_tbl  [NUM_CH];
    logic signed [SCALE_WIDTH-1:0] scale_tbl [NUM_CH];

    // NOTE: the tables must come out of reset at bias 0 / scale 1.0, so they are flops, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                bias_tbl[i]  <= '0;
                scale_tbl[i] <= SCALE_ONE;
            end
        end else if (cfg_we && cfg_addr <= LAST_CH) begin
            bias_tbl[cfg_addr]  <= cfg_bias;
            scale_tbl[cfg_addr] <= cfg_scale;
        end
    end

    logic ready1, ready2, accept;
    logic v1, v2;
    logic [CH_W-1:0] ch_cnt;

    assign ready2      = !v2 || bus.m_ready;
    assign ready1      = !v1 || ready2;
    assign bus.s_ready = ready1;
    assign accept      = bus.s_valid && ready1;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt <= '0;
            err    <= 1'b0;
        end else if (accept) begin
            if (bus.s_last != (ch_cnt == LAST_CH)) err <= 1'b1;
            ch_cnt <= (bus.s_last || ch_cnt == LAST_CH) ? '0 : ch_cnt + CH_W'(1);
        end
    end

    // Stage 1: bias add at full width, table lookup uses the value before any same-cycle write.
    logic signed [SUM_W-1:0]       sum_in, sum1;
    logic signed [SCALE_WIDTH-1:0] scale1;
    logic signed [OUT_WIDTH-1:0]   clip1;
    logic [CH_W-1:0]               ch1;
    logic                          last1;
    act_e                          mode1;

    assign sum_in = SUM_W'($signed(bus.s_data)) + SUM_W'(bias_tbl[ch_cnt]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            sum1   <= '0;
            scale1 <= '0;
            clip1  <= '0;
            ch1    <= '0;
            last1  <= 1'b0;
            mode1  <= ACT_LINEAR;
        end else if (ready1) begin
            v1 <= bus.s_valid;
            if (bus.s_valid) begin
                sum1   <= sum_in;
                scale1 <= scale_tbl[ch_cnt];
                clip1  <= $signed(cfg_clip);
                ch1    <= ch_cnt;
                last1  <= bus.s_last;
                mode1  <= act_e'(act_mode);
            end
        end
    end

    // Stage 2 datapath: clamp bounds compared against the full-width rounded value.
    logic signed [PROD_W-1:0] prod, rounded, lo, hi;
    logic [OUT_WIDTH-1:0]     clamped;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        prod    = PROD_W'(sum1) * PROD_W'(scale1);
        rounded = (prod + ROUND_HALF) >>> FRAC_BITS;
        lo      = OUT_MIN;
        hi      = OUT_MAX;
        case (mode1)
            ACT_LINEAR: ;
            ACT_CLIP: begin
                lo = '0;
                hi = PROD_W'(clip1);
            end
            default: lo = '0;
        endcase
        clamped = rounded[OUT_WIDTH-1:0];
        if (rounded > hi)      clamped = hi[OUT_WIDTH-1:0];
        else if (rounded < lo) clamped = lo[OUT_WIDTH-1:0];
    end

    logic [OUT_WIDTH-1:0] m_data_q;
    logic [CH_W-1:0]      m_ch_q;
    logic                 m_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2       <= 1'b0;
            m_data_q <= '0;
            m_ch_q   <= '0;
            m_last_q <= 1'b0;
        end else if (ready2) begin
            v2 <= v1;
            if (v1) begin
                m_data_q <= clamped;
                m_ch_q   <= ch1;
                m_last_q <= last1;
            end
        end
    end

    assign bus.m_valid = v2;
    assign bus.m_data  = m_data_q;
    assign bus.m_ch    = m_ch_q;
    assign bus.m_last  = m_last_q;
endmodule
